icache_refill: RTL and testbench

Miss-refill engine for the direct-mapped instruction cache (64 sets × 64-byte lines, 52-bit tag). Accepts one miss address at a time, issues a single 8-beat AXI4 INCR read burst for the aligned line, and assembles the returned 64-bit beats into a 512-bit line. When the line is complete it presents a one-cycle fill write (index, tag, line) to the cache arrays.

---
 rtl/icache_pkg.sv | 34 +++
 rtl/icache_line_buffer.sv | 70 +++++++
 rtl/icache_refill.sv | 164 ++++++++++++++++
 tb/tb_icache_refill.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/icache_pkg.sv
// Shared constants, state type and helpers for the instruction-cache refill path.
package icache_pkg;

    localparam int LINE_BYTES     = 64;
    localparam int WORD_BYTES     = 8;
    localparam int WORDS_PER_LINE = LINE_BYTES / WORD_BYTES;
    localparam int OFFSET_BITS    = $clog2(LINE_BYTES);
    localparam int INDEX_BITS     = 6;
    localparam int TAG_BITS       = 52;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [2:0] AXI_SIZE_8B    = 3'b011;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        ADDR = 2'b01,
        DATA = 2'b10,
        FILL = 2'b11
    } refill_state_t;

    // A beat poisons the line if the slave reports an error, answers with a
    // foreign ID, ends the burst early, or keeps sending after the last slot.
    function automatic logic beat_fault(
        input logic [1:0] resp,
        input logic       id_nonzero,
        input logic       last,
        input logic       at_last_slot,
        input logic       overrun
    );
        return (resp != AXI_RESP_OKAY) || id_nonzero || (last && !at_last_slot) || overrun;
    endfunction

endpackage

// File: rtl/icache_line_buffer.sv
// Eight-slot beat assembly buffer plus the saturating beat counter.
module icache_line_buffer
    import icache_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int WORDS      = WORDS_PER_LINE,
    parameter int CNT_W      = $clog2(WORDS)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        clear,
    input  logic                        wr_en,
    input  logic [DATA_WIDTH-1:0]       wr_data,
    output logic [WORDS*DATA_WIDTH-1:0] line_next,
    output logic [CNT_W-1:0]            beat_cnt,
    output logic                        last_slot_done
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WORDS - 1);

    logic [WORDS-1:0][DATA_WIDTH-1:0] slots_r;
    logic [WORDS-1:0][DATA_WIDTH-1:0] slots_next_s;
    logic [CNT_W-1:0]                 beat_cnt_r;
    logic                             last_done_r;

    // Merge the incoming beat into its slot so the owner can snapshot the finished line on the last beat.
    always_comb begin
        slots_next_s = slots_r;
        if (wr_en) begin
            slots_next_s[beat_cnt_r] = wr_data;
        end else begin
            slots_next_s = slots_r;
        end
    end

    // Slot storage; contents survive a new miss so early-terminated bursts keep stale upper slots.
    always_ff @(posedge clk) begin
        if (reset) begin
            slots_r <= {(WORDS*DATA_WIDTH){1'b0}};
        end else begin
            slots_r <= slots_next_s;
        end
    end

    // Beat counter saturates on the last slot; a flag remembers that the last slot has been written.
    always_ff @(posedge clk) begin
        if (reset) begin
            beat_cnt_r  <= {CNT_W{1'b0}};
            last_done_r <= 1'b0;
        end else if (clear) begin
            beat_cnt_r  <= {CNT_W{1'b0}};
            last_done_r <= 1'b0;
        end else if (wr_en) begin
            if (beat_cnt_r != CNT_MAX) begin
                beat_cnt_r <= beat_cnt_r + CNT_W'(1);
            end else begin
                beat_cnt_r <= beat_cnt_r;
            end
            last_done_r <= last_done_r | (beat_cnt_r == CNT_MAX);
        end else begin
            beat_cnt_r  <= beat_cnt_r;
            last_done_r <= last_done_r;
        end
    end

    assign line_next      = slots_next_s;
    assign beat_cnt       = beat_cnt_r;
    assign last_slot_done = last_done_r;

endmodule

// File: rtl/icache_refill.sv
// I-cache miss refill engine: one 8-beat AXI4 INCR read per miss, one-cycle fill write.
module icache_refill
    import icache_pkg::*;
#(
    parameter int ID_WIDTH   = 13,
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 miss_valid,
    input  logic [ADDR_WIDTH-1:0]                miss_addr,
    output logic                                 miss_ready,
    output logic [ID_WIDTH-1:0]                  m_axi_arid,
    output logic [ADDR_WIDTH-1:0]                m_axi_araddr,
    output logic [7:0]                           m_axi_arlen,
    output logic [2:0]                           m_axi_arsize,
    output logic [1:0]                           m_axi_arburst,
    output logic                                 m_axi_arvalid,
    input  logic                                 m_axi_arready,
    input  logic [ID_WIDTH-1:0]                  m_axi_rid,
    input  logic [DATA_WIDTH-1:0]                m_axi_rdata,
    input  logic [1:0]                           m_axi_rresp,
    input  logic                                 m_axi_rlast,
    input  logic                                 m_axi_rvalid,
    output logic                                 m_axi_rready,
    output logic                                 fill_valid,
    output logic [INDEX_BITS-1:0]                fill_index,
    output logic [TAG_BITS-1:0]                  fill_tag,
    output logic [WORDS_PER_LINE*DATA_WIDTH-1:0] fill_line,
    output logic                                 fill_error
);

    localparam int LINE_WIDTH = WORDS_PER_LINE * DATA_WIDTH;
    localparam int CNT_W      = $clog2(WORDS_PER_LINE);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WORDS_PER_LINE - 1);
    localparam logic [ADDR_WIDTH-1:0] OFFSET_MASK =
        {{(ADDR_WIDTH-OFFSET_BITS){1'b0}}, {OFFSET_BITS{1'b1}}};

    refill_state_t           state_r;
    refill_state_t           state_next_s;
    logic [ADDR_WIDTH-1:0]   addr_r;
    logic                    error_r;
    logic                    miss_ready_r;
    logic                    arvalid_r;
    logic                    rready_r;
    logic                    fill_valid_r;
    logic [LINE_WIDTH-1:0]   fill_line_r;
    logic                    accept_s;
    logic                    r_hs_s;
    logic [LINE_WIDTH-1:0]   line_next_s;
    logic [CNT_W-1:0]        beat_cnt_s;
    logic                    last_slot_done_s;

    assign accept_s = (state_r == IDLE) && miss_valid;
    assign r_hs_s   = (state_r == DATA) && m_axi_rvalid;

    icache_line_buffer #(
        .DATA_WIDTH (DATA_WIDTH),
        .WORDS      (WORDS_PER_LINE),
        .CNT_W      (CNT_W)
    ) u_line_buffer (
        .clk            (clk),
        .reset          (reset),
        .clear          (accept_s),
        .wr_en          (r_hs_s),
        .wr_data        (m_axi_rdata),
        .line_next      (line_next_s),
        .beat_cnt       (beat_cnt_s),
        .last_slot_done (last_slot_done_s)
    );

    // Next-state decode; the beat carrying rlast always ends the burst.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (miss_valid) state_next_s = ADDR;
                else            state_next_s = IDLE;
            end
            ADDR: begin
                if (m_axi_arready) state_next_s = DATA;
                else               state_next_s = ADDR;
            end
            DATA: begin
                if (m_axi_rvalid && m_axi_rlast) state_next_s = FILL;
                else                             state_next_s = DATA;
            end
            FILL:    state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Handshake strobes are flops loaded from the next state, so each one tracks the current state exactly.
    always_ff @(posedge clk) begin
        if (reset) begin
            miss_ready_r <= 1'b1;
            arvalid_r    <= 1'b0;
            rready_r     <= 1'b0;
            fill_valid_r <= 1'b0;
        end else begin
            miss_ready_r <= (state_next_s == IDLE);
            arvalid_r    <= (state_next_s == ADDR);
            rready_r     <= (state_next_s == DATA);
            fill_valid_r <= (state_next_s == FILL);
        end
    end

    // Latch the line-aligned request address and accumulate the sticky fault flag across beats.
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_r  <= {ADDR_WIDTH{1'b0}};
            error_r <= 1'b0;
        end else if (accept_s) begin
            addr_r  <= miss_addr & ~OFFSET_MASK;
            error_r <= 1'b0;
        end else if (r_hs_s) begin
            addr_r  <= addr_r;
            error_r <= error_r | beat_fault(m_axi_rresp,
                                            (m_axi_rid != {ID_WIDTH{1'b0}}),
                                            m_axi_rlast,
                                            (beat_cnt_s == CNT_MAX),
                                            last_slot_done_s);
        end else begin
            addr_r  <= addr_r;
            error_r <= error_r;
        end
    end

    // Snapshot the completed line on the final beat so fill_line only changes when a fill is presented.
    always_ff @(posedge clk) begin
        if (reset) begin
            fill_line_r <= {LINE_WIDTH{1'b0}};
        end else if (r_hs_s && m_axi_rlast) begin
            fill_line_r <= line_next_s;
        end else begin
            fill_line_r <= fill_line_r;
        end
    end

    assign miss_ready    = miss_ready_r;
    assign m_axi_arid    = {ID_WIDTH{1'b0}};
    assign m_axi_araddr  = addr_r;
    assign m_axi_arlen   = 8'd7;
    assign m_axi_arsize  = AXI_SIZE_8B;
    assign m_axi_arburst = AXI_BURST_INCR;
    assign m_axi_arvalid = arvalid_r;
    assign m_axi_rready  = rready_r;
    assign fill_valid    = fill_valid_r;
    assign fill_index    = addr_r[OFFSET_BITS +: INDEX_BITS];
    assign fill_tag      = addr_r[OFFSET_BITS+INDEX_BITS +: TAG_BITS];
    assign fill_line     = fill_line_r;
    assign fill_error    = error_r;

endmodule

// File: tb/tb_icache_refill.sv
// Self-checking bench for icache_refill: directed scenarios plus randomized bursts against a line/fault model.
module tb_icache_refill;

    logic          clk = 1'b0;
    logic          reset;
    logic          miss_valid;
    logic [63:0]   miss_addr;
    logic          miss_ready;
    logic [12:0]   m_axi_arid;
    logic [63:0]   m_axi_araddr;
    logic [7:0]    m_axi_arlen;
    logic [2:0]    m_axi_arsize;
    logic [1:0]    m_axi_arburst;
    logic          m_axi_arvalid;
    logic          m_axi_arready;
    logic [12:0]   m_axi_rid;
    logic [63:0]   m_axi_rdata;
    logic [1:0]    m_axi_rresp;
    logic          m_axi_rlast;
    logic          m_axi_rvalid;
    logic          m_axi_rready;
    logic          fill_valid;
    logic [5:0]    fill_index;
    logic [51:0]   fill_tag;
    logic [511:0]  fill_line;
    logic          fill_error;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    logic [63:0] exp_line [8];

    icache_refill dut (
        .clk           (clk),
        .reset         (reset),
        .miss_valid    (miss_valid),
        .miss_addr     (miss_addr),
        .miss_ready    (miss_ready),
        .m_axi_arid    (m_axi_arid),
        .m_axi_araddr  (m_axi_araddr),
        .m_axi_arlen   (m_axi_arlen),
        .m_axi_arsize  (m_axi_arsize),
        .m_axi_arburst (m_axi_arburst),
        .m_axi_arvalid (m_axi_arvalid),
        .m_axi_arready (m_axi_arready),
        .m_axi_rid     (m_axi_rid),
        .m_axi_rdata   (m_axi_rdata),
        .m_axi_rresp   (m_axi_rresp),
        .m_axi_rlast   (m_axi_rlast),
        .m_axi_rvalid  (m_axi_rvalid),
        .m_axi_rready  (m_axi_rready),
        .fill_valid    (fill_valid),
        .fill_index    (fill_index),
        .fill_tag      (fill_tag),
        .fill_line     (fill_line),
        .fill_error    (fill_error)
    );

    always #5 clk = ~clk;

    // Hard stop in case a scenario wedges outside its own bounded waits.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    function automatic logic [511:0] exp_vec();
        logic [511:0] v;
        for (int k = 0; k < 8; k++) v[64*k +: 64] = exp_line[k];
        return v;
    endfunction

    // mode: 0 clean, 1 SLVERR on beat 3, 2 rlast on beat 5, 3 nine beats (rlast on 9th),
    //       4 reset after beat 4, 5 random resp/id faults
    task automatic run_miss(input logic [63:0] addr, input int ar_wait, input int gap_max,
                            input int mode, input bit toggle, input bit check_lat);
        logic [63:0] line_addr;
        logic [63:0] d;
        logic [1:0]  resp;
        logic [12:0] id;
        bit          last;
        bit          exp_err;
        int          n_beats;
        int          slot;
        int          gap;
        int          n;

        line_addr = addr - (addr % 64);
        n_beats   = (mode == 2) ? 6 : (mode == 3) ? 9 : (mode == 4) ? 4 : 8;
        exp_err   = 1'b0;

        n = 0;
        while (miss_ready !== 1'b1 && n < 50) begin tick(); n++; end
        chk("idle_before_miss", miss_ready, 1'b1);

        miss_valid    = 1'b1;
        miss_addr     = addr;
        m_axi_arready = (ar_wait == 0);
        cyc           = 1;
        tick();
        miss_valid = 1'b0;
        miss_addr  = {$urandom, $urandom};

        chk("miss_ready_busy", miss_ready, 1'b0);
        chk("arvalid_on", m_axi_arvalid, 1'b1);
        chk("araddr", m_axi_araddr, line_addr);
        chk("arlen", m_axi_arlen, 8'd7);
        chk("arsize", m_axi_arsize, 3'b011);
        chk("arburst", m_axi_arburst, 2'b01);
        chk("arid", m_axi_arid, 13'd0);

        for (int w = 0; w < ar_wait; w++) begin
            tick();
            chk("arvalid_hold", m_axi_arvalid, 1'b1);
            chk("araddr_stable", m_axi_araddr, line_addr);
        end
        m_axi_arready = 1'b1;
        tick();
        if (ar_wait != 0) m_axi_arready = 1'b0;
        chk("arvalid_off", m_axi_arvalid, 1'b0);

        for (int i = 0; i < n_beats; i++) begin
            gap = (gap_max == 0) ? 0 : $urandom_range(0, gap_max);
            for (int g = 0; g < gap; g++) begin
                m_axi_rvalid = 1'b0;
                if (toggle) miss_valid = 1'($urandom_range(0, 1));
                tick();
                if (toggle) begin
                    chk("ignored_miss_ready", miss_ready, 1'b0);
                    chk("ignored_no_ar", m_axi_arvalid, 1'b0);
                end
            end
            d    = check_lat ? 64'h1111_1111_1111_1111 * 64'(i + 1) : {$urandom, $urandom};
            resp = 2'b00;
            id   = 13'd0;
            if (mode == 1 && i == 3) resp = 2'b10;
            if (mode == 5) begin
                resp = ($urandom_range(0, 7) == 0) ? 2'b10 : 2'b00;
                id   = ($urandom_range(0, 7) == 0) ? 13'd5 : 13'd0;
            end
            last = (i == n_beats - 1) && (mode != 4);
            m_axi_rvalid = 1'b1;
            m_axi_rdata  = d;
            m_axi_rresp  = resp;
            m_axi_rid    = id;
            m_axi_rlast  = last;
            if (toggle) miss_valid = 1'($urandom_range(0, 1));
            chk("rready_on", m_axi_rready, 1'b1);
            tick();
            if (toggle) begin
                chk("ignored_miss_ready", miss_ready, 1'b0);
                chk("ignored_no_ar", m_axi_arvalid, 1'b0);
            end
            // Reference: beats beyond the eighth land in the last slot.
            slot = (i < 7) ? i : 7;
            exp_line[slot] = d;
            exp_err = exp_err | (resp != 2'b00) | (id != 13'd0) | (last && slot != 7) | (i >= 8);
        end
        m_axi_rvalid = 1'b0;
        m_axi_rlast  = 1'b0;
        miss_valid   = 1'b0;

        if (mode == 4) begin
            reset = 1'b1;
            tick();
            reset = 1'b0;
            for (int k = 0; k < 8; k++) exp_line[k] = 64'd0;
            chk("reset_no_fill", fill_valid, 1'b0);
            chk("reset_ready", miss_ready, 1'b1);
            chk("reset_line", fill_line, exp_vec());
            for (int k = 0; k < 3; k++) begin
                tick();
                chk("reset_no_late_fill", fill_valid, 1'b0);
            end
        end else begin
            n = 0;
            while (fill_valid !== 1'b1 && n < 20) begin tick(); n++; end
            chk("fill_valid", fill_valid, 1'b1);
            // Accept cycle + AR cycle + 8 beat cycles precede the fill cycle.
            if (check_lat) chk("latency", cyc, 11);
            chk("fill_index", fill_index, (line_addr / 64) % 64);
            chk("fill_tag", fill_tag, line_addr / 4096);
            chk("fill_line", fill_line, exp_vec());
            chk("fill_error", fill_error, exp_err);
            tick();
            chk("fill_single_pulse", fill_valid, 1'b0);
            chk("ready_after_fill", miss_ready, 1'b1);
        end
    endtask

    initial begin
        reset         = 1'b1;
        miss_valid    = 1'b0;
        miss_addr     = 64'd0;
        m_axi_arready = 1'b0;
        m_axi_rid     = 13'd0;
        m_axi_rdata   = 64'd0;
        m_axi_rresp   = 2'b00;
        m_axi_rlast   = 1'b0;
        m_axi_rvalid  = 1'b0;
        for (int k = 0; k < 8; k++) exp_line[k] = 64'd0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        chk("rst_miss_ready", miss_ready, 1'b1);
        chk("rst_arvalid", m_axi_arvalid, 1'b0);
        chk("rst_rready", m_axi_rready, 1'b0);
        chk("rst_fill_valid", fill_valid, 1'b0);
        chk("rst_fill_error", fill_error, 1'b0);
        chk("rst_fill_line", fill_line, 512'd0);

        // Zero-wait burst; 0x12345 maps to line 0x12340, index 0x0D, tag 0x12.
        run_miss(64'h0000_0000_0001_2345, 0, 0, 0, 1'b0, 1'b1);
        // Address and data backpressure.
        run_miss({$urandom, $urandom}, 5, 3, 0, 1'b0, 1'b0);
        // Fault scenarios.
        run_miss({$urandom, $urandom}, 1, 2, 1, 1'b0, 1'b0);
        run_miss({$urandom, $urandom}, 0, 1, 2, 1'b0, 1'b0);
        run_miss({$urandom, $urandom}, 2, 1, 3, 1'b0, 1'b0);
        // Reset in the middle of DATA, then a clean miss.
        run_miss({$urandom, $urandom}, 0, 1, 4, 1'b0, 1'b0);
        run_miss({$urandom, $urandom}, 0, 0, 0, 1'b0, 1'b1);
        // miss_valid wiggled while a burst is in flight.
        run_miss({$urandom, $urandom}, 3, 3, 0, 1'b1, 1'b0);
        // Randomized bursts with sporadic faults.
        for (int r = 0; r < 12; r++) begin
            run_miss({$urandom, $urandom}, $urandom_range(0, 4), $urandom_range(0, 3),
                     5, 1'($urandom_range(0, 1)), 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
